// File: rtl/audio_cpu_regs_if.sv
// CPU register bus between a bus master and the audio register block.
// Single-cycle strobes in; registered read data and valid out.
interface audio_cpu_regs_if;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rd_valid;

  modport master (output cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_rd_valid);
  modport slave  (input  cpu_wr, cpu_rd, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_rd_valid);
endinterface

// File: rtl/audio_cpu_regs.sv
// CPU-visible control/status registers for the audio path, with FIR
// coefficient and EQ write strobes, write counters and full limits.
module audio_cpu_regs #(
  parameter int NUM_FILTERS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  audio_cpu_regs_if.slave         bus,
  input  logic [7:0]              audio_status_in,
  input  logic [7:0]              bit_cnt_in,
  output logic [7:0]              audio_control,
  output logic [7:0]              coef_select,
  output logic [7:0]              coefs_per_tap_lsb,
  output logic [7:0]              coef_wr_lsb_data,
  output logic [7:0]              coef_wr_msb_data,
  output logic [7:0]              eq_select,
  output logic [7:0]              eq_wr_lsb_data,
  output logic [7:0]              eq_wr_msb_data,
  output logic [7:0]              test_reg,
  output logic [7:0]              fe_test_reg,
  output logic [7:0]              triangle_inc_reg,
  output logic                    coef_wr_en,
  output logic                    eq_wr_en,
  output logic                    coef_full,
  output logic                    eq_full
);

  localparam logic [7:0] EQ_LIMIT = 8'(2 * NUM_FILTERS);

  logic [13:0] coef_count;
  logic [7:0]  eq_count;
  logic [13:0] coef_limit;
  logic        coef_full_q;
  logic        coef_at_limit;
  logic [1:0]  coef_vld_pipe;
  logic [1:0]  eq_vld_pipe;
  logic [1:0]  coef_rst_dly;
  logic [1:0]  eq_rst_dly;
  logic [7:0]  rd_mux;
  logic        coef_hit;
  logic        eq_hit;
  logic        ctrl_wr;

  assign ctrl_wr  = bus.cpu_wr && (bus.cpu_addr == 4'h0);
  assign coef_hit = bus.cpu_wr && (bus.cpu_addr == 4'h4) && !coef_full;
  assign eq_hit   = bus.cpu_wr && (bus.cpu_addr == 4'h7) && !eq_full;

  assign coef_limit    = 14'(NUM_FILTERS) *
                         ({5'd0, audio_control[6], coefs_per_tap_lsb} + 14'd1);
  assign coef_at_limit = (coef_count >= coef_limit);
  // Sticky so that raising the limit again does not release a full FIR bank.
  assign coef_full     = coef_full_q || coef_at_limit;
  assign eq_full       = (eq_count >= EQ_LIMIT);

  // Strobes trail the data write by one cycle so the data is already stable.
  assign coef_wr_en = coef_vld_pipe[1];
  assign eq_wr_en   = eq_vld_pipe[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_control     <= '0;
      coef_select       <= '0;
      coefs_per_tap_lsb <= '0;
      coef_wr_lsb_data  <= '0;
      coef_wr_msb_data  <= '0;
      eq_select         <= '0;
      eq_wr_lsb_data    <= '0;
      eq_wr_msb_data    <= '0;
      test_reg          <= '0;
      fe_test_reg       <= '0;
      triangle_inc_reg  <= '0;
      coef_rst_dly      <= '0;
      eq_rst_dly        <= '0;
    end else begin
      coef_rst_dly <= {coef_rst_dly[0], ctrl_wr && bus.cpu_wdata[7]};
      eq_rst_dly   <= {eq_rst_dly[0],   ctrl_wr && bus.cpu_wdata[5]};
      if (coef_rst_dly[1]) audio_control[7] <= 1'b0;
      if (eq_rst_dly[1])   audio_control[5] <= 1'b0;
      if (bus.cpu_wr) begin
        case (bus.cpu_addr)
          4'h0: audio_control     <= bus.cpu_wdata;
          4'h1: coef_select       <= bus.cpu_wdata;
          4'h2: coefs_per_tap_lsb <= bus.cpu_wdata;
          4'h3: coef_wr_lsb_data  <= bus.cpu_wdata;
          4'h4: coef_wr_msb_data  <= bus.cpu_wdata;
          4'h5: eq_select         <= bus.cpu_wdata;
          4'h6: eq_wr_lsb_data    <= bus.cpu_wdata;
          4'h7: eq_wr_msb_data    <= bus.cpu_wdata;
          4'h8: test_reg          <= bus.cpu_wdata;
          4'h9: fe_test_reg       <= bus.cpu_wdata;
          4'hA: triangle_inc_reg  <= bus.cpu_wdata;
          default: ;
        endcase
      end
    end
  end

  // Address-pointer resets take priority over an in-flight strobe's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_vld_pipe <= '0;
      eq_vld_pipe   <= '0;
      coef_count    <= '0;
      eq_count      <= '0;
      coef_full_q   <= 1'b0;
    end else begin
      coef_vld_pipe <= {coef_vld_pipe[0], coef_hit};
      eq_vld_pipe   <= {eq_vld_pipe[0], eq_hit};
      if (coef_rst_dly[0])  coef_count <= '0;
      else if (coef_wr_en)  coef_count <= coef_count + 14'd1;
      coef_full_q <= coef_rst_dly[0] ? 1'b0 : (coef_full_q || coef_at_limit);
      if (eq_rst_dly[0])    eq_count <= '0;
      else if (eq_wr_en)    eq_count <= eq_count + 8'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.cpu_addr)
      4'h0: rd_mux = audio_control;
      4'h1: rd_mux = coef_select;
      4'h2: rd_mux = coefs_per_tap_lsb;
      4'h3: rd_mux = coef_wr_lsb_data;
      4'h4: rd_mux = coef_wr_msb_data;
      4'h5: rd_mux = eq_select;
      4'h6: rd_mux = eq_wr_lsb_data;
      4'h7: rd_mux = eq_wr_msb_data;
      4'h8: rd_mux = test_reg;
      4'h9: rd_mux = fe_test_reg;
      4'hA: rd_mux = triangle_inc_reg;
      4'hB: rd_mux = audio_status_in;
      4'hC: rd_mux = bit_cnt_in;
      4'hD: rd_mux = coef_count[7:0];
      4'hE: rd_mux = {eq_full, coef_full, coef_count[13:8]};
      4'hF: rd_mux = eq_count;
      default: rd_mux = '0;
    endcase
  end

  // Read samples pre-write state, so a same-cycle write is not visible yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_rdata    <= '0;
      bus.cpu_rd_valid <= 1'b0;
    end else begin
      bus.cpu_rd_valid <= bus.cpu_rd;
      if (bus.cpu_rd) bus.cpu_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_audio_cpu_regs.sv
// Self-checking bench for audio_cpu_regs: register table, read scoreboard,
// and hand-written sequences for strobe, limit and reset corner cases.
module tb_audio_cpu_regs;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] audio_status_in = 8'h03;
  logic [7:0] bit_cnt_in = 8'h9C;
  logic [7:0] audio_control, coef_select, coefs_per_tap_lsb, coef_wr_lsb_data;
  logic [7:0] coef_wr_msb_data, eq_select, eq_wr_lsb_data, eq_wr_msb_data;
  logic [7:0] test_reg, fe_test_reg, triangle_inc_reg;
  logic       coef_wr_en, eq_wr_en, coef_full, eq_full;

  audio_cpu_regs_if bus();

  audio_cpu_regs #(.NUM_FILTERS(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .audio_status_in(audio_status_in), .bit_cnt_in(bit_cnt_in),
    .audio_control(audio_control), .coef_select(coef_select),
    .coefs_per_tap_lsb(coefs_per_tap_lsb), .coef_wr_lsb_data(coef_wr_lsb_data),
    .coef_wr_msb_data(coef_wr_msb_data), .eq_select(eq_select),
    .eq_wr_lsb_data(eq_wr_lsb_data), .eq_wr_msb_data(eq_wr_msb_data),
    .test_reg(test_reg), .fe_test_reg(fe_test_reg),
    .triangle_inc_reg(triangle_inc_reg), .coef_wr_en(coef_wr_en),
    .eq_wr_en(eq_wr_en), .coef_full(coef_full), .eq_full(eq_full));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[16];
  logic [7:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         failures = 0;
  int         coef_pulses = 0;
  int         eq_pulses = 0;
  int         base;

  // Strobe cycles counted on the rising edge; main thread samples on falling.
  always @(posedge clk) begin
    if (coef_wr_en) coef_pulses++;
    if (eq_wr_en)   eq_pulses++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic wr, input logic rd, input logic [3:0] a,
                      input logic [7:0] d, input logic [7:0] e, input string nm);
    bus.cpu_wr = wr; bus.cpu_rd = rd; bus.cpu_addr = a; bus.cpu_wdata = d;
    if (rd) begin exp_q.push_back(e); name_q.push_back(nm); end
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    if (rd) begin
      chk({nm, "_vld"}, 32'(bus.cpu_rd_valid), 32'd1);
      if (exp_q.size() > 0) chk(name_q.pop_front(), 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    xfer(1'b1, 1'b0, a, d, 8'h00, "");
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
    xfer(1'b0, 1'b1, a, 8'h00, e, nm);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] port_val(input logic [3:0] a);
    case (a)
      4'h0: return audio_control;
      4'h1: return coef_select;
      4'h2: return coefs_per_tap_lsb;
      4'h3: return coef_wr_lsb_data;
      4'h4: return coef_wr_msb_data;
      4'h5: return eq_select;
      4'h6: return eq_wr_lsb_data;
      4'h7: return eq_wr_msb_data;
      4'h8: return test_reg;
      4'h9: return fe_test_reg;
      4'hA: return triangle_inc_reg;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic any_out();
    return |{audio_control, coef_select, coefs_per_tap_lsb, coef_wr_lsb_data,
             coef_wr_msb_data, eq_select, eq_wr_lsb_data, eq_wr_msb_data,
             test_reg, fe_test_reg, triangle_inc_reg, coef_wr_en, eq_wr_en,
             coef_full, eq_full, bus.cpu_rdata, bus.cpu_rd_valid};
  endfunction

  initial begin
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    // RO entries carry the write attempt of 0xFF that must be ignored.
    vecs = '{
      '{4'h0, 8'h41, 8'h41}, '{4'h1, 8'h3C, 8'h3C}, '{4'h2, 8'h12, 8'h12},
      '{4'h3, 8'hA7, 8'hA7}, '{4'h4, 8'h5E, 8'h5E}, '{4'h5, 8'hA5, 8'hA5},
      '{4'h6, 8'h69, 8'h69}, '{4'h7, 8'hC3, 8'hC3}, '{4'h8, 8'hF0, 8'hF0},
      '{4'h9, 8'h0F, 8'h0F}, '{4'hA, 8'h81, 8'h81}, '{4'hB, 8'hFF, 8'h03},
      '{4'hC, 8'hFF, 8'h9C}, '{4'hD, 8'hFF, 8'h01}, '{4'hE, 8'hFF, 8'h00},
      '{4'hF, 8'hFF, 8'h01}};

    // Reset state
    idle(2);
    chk("rst_any_out", 32'(any_out()), 32'd0);
    reset = 1'b0;
    idle(1);
    chk("post_rst_any_out", 32'(any_out()), 32'd0);

    // Register table: write all, then read back and check driven ports
    foreach (vecs[i]) wr(vecs[i].addr, vecs[i].wdata);
    idle(3);
    foreach (vecs[i]) rd(vecs[i].addr, vecs[i].exp, $sformatf("tbl_rd_%0h", vecs[i].addr));
    for (int i = 0; i < 11; i++)
      chk($sformatf("tbl_port_%0h", vecs[i].addr), 32'(port_val(vecs[i].addr)), 32'(vecs[i].exp));
    idle(1);
    chk("rd_valid_one_cycle", 32'(bus.cpu_rd_valid), 32'd0);

    // 16 coefficient writes reach the limit, the 17th is suppressed
    do_reset();
    wr(4'h2, 8'h03);
    wr(4'h0, 8'h00);
    base = coef_pulses;
    for (int i = 0; i < 16; i++) begin wr(4'h4, 8'(i)); idle(3); end
    chk("coef_16_pulses", 32'(coef_pulses - base), 32'd16);
    chk("coef_full_16", 32'(coef_full), 32'd1);
    rd(4'hD, 8'd16, "coef_cnt_16");
    rd(4'hE, 8'h40, "status_coef_full");
    wr(4'h4, 8'hEE);
    idle(4);
    chk("coef_17th_suppressed", 32'(coef_pulses - base), 32'd16);
    chk("coef_17th_data", 32'(coef_wr_msb_data), 32'hEE);

    // Self-clearing coef_addr_rst
    wr(4'h0, 8'h80);
    chk("ctrl_bit7_set", 32'(audio_control), 32'h80);
    idle(1);
    chk("coef_full_cleared", 32'(coef_full), 32'd0);
    chk("ctrl_bit7_hold", 32'(audio_control), 32'h80);
    idle(1);
    chk("ctrl_bit7_selfclr", 32'(audio_control), 32'h00);
    rd(4'h0, 8'h00, "ctrl_rd_3cyc");
    rd(4'hD, 8'h00, "coef_cnt_cleared");

    // Limit shrinking below the count, then sticky full
    for (int i = 0; i < 5; i++) begin wr(4'h4, 8'h10); idle(3); end
    rd(4'hD, 8'd5, "coef_cnt_5");
    chk("coef_not_full_5", 32'(coef_full), 32'd0);
    wr(4'h2, 8'h00);
    idle(1);
    chk("coef_full_shrink", 32'(coef_full), 32'd1);
    wr(4'h2, 8'h03);
    idle(2);
    chk("coef_full_sticky", 32'(coef_full), 32'd1);
    base = coef_pulses;
    wr(4'h4, 8'h01);
    idle(3);
    chk("coef_sticky_suppress", 32'(coef_pulses - base), 32'd0);
    wr(4'h0, 8'h80);
    idle(3);
    chk("coef_sticky_cleared", 32'(coef_full), 32'd0);

    // Pending strobe coinciding with a count reset
    base = coef_pulses;
    wr(4'h4, 8'h11);
    wr(4'h0, 8'h80);
    idle(4);
    chk("rst_vs_strobe_pulse", 32'(coef_pulses - base), 32'd1);
    rd(4'hD, 8'h00, "rst_vs_strobe_cnt");

    // Back-to-back strobes
    base = coef_pulses;
    wr(4'h4, 8'h21);
    wr(4'h4, 8'h22);
    idle(4);
    chk("b2b_pulses", 32'(coef_pulses - base), 32'd2);
    rd(4'hD, 8'd2, "b2b_cnt");

    // Simultaneous write and read returns the old value
    do_reset();
    xfer(1'b1, 1'b1, 4'h5, 8'hA5, 8'h00, "simul_old");
    rd(4'h5, 8'hA5, "simul_new");
    chk("simul_port", 32'(eq_select), 32'hA5);

    // EQ limit: 9 writes give 8 strobes
    do_reset();
    base = eq_pulses;
    for (int i = 0; i < 9; i++) begin wr(4'h7, 8'(i + 1)); idle(3); end
    chk("eq_8_pulses", 32'(eq_pulses - base), 32'd8);
    chk("eq_full", 32'(eq_full), 32'd1);
    rd(4'hE, 8'h80, "status_eq_full");
    rd(4'hF, 8'd8, "eq_cnt_8");
    wr(4'h0, 8'h20);
    idle(2);
    chk("eq_full_cleared", 32'(eq_full), 32'd0);
    rd(4'hF, 8'h00, "eq_cnt_cleared");
    rd(4'h0, 8'h00, "ctrl_bit5_selfclr");

    // Reset between a coefficient write and its strobe
    do_reset();
    base = coef_pulses;
    wr(4'h4, 8'h77);
    reset = 1'b1;
    #1;
    chk("midrst_zero_now", 32'(any_out()), 32'd0);
    idle(3);
    chk("midrst_zero_held", 32'(any_out()), 32'd0);
    reset = 1'b0;
    wr(4'h8, 8'h5A);
    chk("first_wr_after_rst", 32'(test_reg), 32'h5A);
    idle(4);
    chk("midrst_no_strobe", 32'(coef_pulses - base), 32'd0);
    chk("midrst_msb_data", 32'(coef_wr_msb_data), 32'h00);

    // Read-only status input
    audio_status_in = 8'h5C;
    rd(4'hB, 8'h5C, "status_in_rd");
    wr(4'hB, 8'hFF);
    rd(4'hB, 8'h5C, "status_in_ro");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_cpu_regs.md
AUDIO_CPU_REGS -- requirements
Module: audio_cpu_regs

Interface
REQ-001 Parameter NUM_FILTERS, default 4: number of FIR bands; bounds the coefficient and EQ write counts.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_wr  input  1  single-cycle write strobe from the CPU bus.
REQ-005 cpu_rd  input  1  single-cycle read strobe.
REQ-006 cpu_addr  input  4  register address.
REQ-007 cpu_wdata  input  8  write data.
REQ-008 cpu_rdata  output  8  read data, registered.
REQ-009 cpu_rd_valid  output  1  strobe marking cpu_rdata valid.
REQ-010 audio_status_in, bit_cnt_in  input  8 each  status values from the audio path, readable only.
REQ-011 audio_control, coef_select, coefs_per_tap_lsb, coef_wr_lsb_data, coef_wr_msb_data, eq_select, eq_wr_lsb_data, eq_wr_msb_data, test_reg, fe_test_reg, triangle_inc_reg  output  8 each  register values driven to the audio path.
REQ-012 coef_wr_en, eq_wr_en  output  1 each  single-cycle write strobes to the FIR and EQ memories.
REQ-013 coef_full, eq_full  output  1 each  write-count limit reached.

Function
REQ-014 Address map:
- 0x0 audio_control
- 0x1 coef_select
- 0x2 coefs_per_tap_lsb
- 0x3 coef_wr_lsb_data
- 0x4 coef_wr_msb_data
- 0x5 eq_select
- 0x6 eq_wr_lsb_data
- 0x7 eq_wr_msb_data
- 0x8 test_reg
- 0x9 fe_test_reg
- 0xA triangle_inc_reg
- 0xB audio_status_in (RO)
- 0xC bit_cnt_in (RO)
- 0xD coef_count[7:0] (RO)
- 0xE {eq_full, coef_full, coef_count[13:8]} (RO)
- 0xF eq_count (RO)
REQ-015 Write behaviour: on cpu_wr to 0x0-0xA, the register updates at the next clk edge; writes to 0xB-0xF are ignored.
REQ-016 Read behaviour: on cpu_rd, cpu_rdata and cpu_rd_valid are registered one cycle later; cpu_rd_valid lasts exactly one cycle.
REQ-017 Simultaneous cpu_wr and cpu_rd: the write is performed and the read returns the pre-write value.
REQ-018 Coefficient write trigger: a write to 0x4 while coef_full=0 asserts coef_wr_en for exactly one cycle, one cycle after the write edge, so coef_wr_msb_data is already stable when the strobe is seen.
REQ-019 Coefficient counter: each coef_wr_en increments the 14-bit coef_count.
REQ-020 Coefficient limit: limit = NUM_FILTERS*({audio_control[6], coefs_per_tap_lsb}+1), computed as a 14-bit product.
- coef_full asserts when coef_count equals the limit.
- A write to 0x4 while coef_full=1 updates the register but suppresses coef_wr_en.
REQ-021 EQ write trigger: a write to 0x7 asserts eq_wr_en in the same manner as REQ-018.
- eq_count is 8-bit.
- eq_full asserts at eq_count = 2*NUM_FILTERS; when set, eq_wr_en is suppressed.
REQ-022 Self-clearing reset bits: audio_control[7] (coef_addr_rst) and audio_control[5] (eq_addr_rst) clear automatically two cycles after being written 1.
- coef_addr_rst clears coef_count and coef_full, effective the cycle after the write.
- eq_addr_rst clears eq_count and eq_full, effective the cycle after the write.
- All other audio_control bits hold their written value.
REQ-023 Pending strobe vs count reset: if a count reset and a pending write strobe fall in the same cycle, the reset wins, the count goes to 0, and the strobe is still emitted.
REQ-024 Back-to-back writes to 0x4 on consecutive cycles each produce one strobe; strobes never merge or drop unless suppressed by the full flag.
REQ-025 Limit shrinking below count: if coefs_per_tap is rewritten so that the limit falls below coef_count, coef_full asserts immediately (compare is >=) and stays set until coef_addr_rst.

Reset
REQ-026 While reset is high:
- all writable registers are 0x00, so audio_enable=0;
- all counts and full flags are 0;
- coef_wr_en, eq_wr_en, cpu_rd_valid and cpu_rdata are 0.
REQ-027 Reset mid-operation: reset asserted between a write to 0x4 and its strobe cancels the strobe; no coef_wr_en appears after reset release.
REQ-028 After reset release, the first cpu_wr is honoured on the first clk edge.

Verification
REQ-029 Scenario: write 0x2=0x03, 0x0 bit6=0, NUM_FILTERS=4, then 16 writes to 0x4 -> 16 coef_wr_en pulses, coef_count=16, coef_full=1; a 17th write produces no strobe.
REQ-030 Scenario: write 0x0=0x80 with coef_count=16 -> coef_count=0, coef_full=0; read 0x0 three cycles later returns 0x00.
REQ-031 Scenario: cpu_wr 0x5=0xA5 together with cpu_rd 0x5 (old value 0x00) -> cpu_rdata=0x00 and cpu_rd_valid after one cycle; the next read returns 0xA5.
REQ-032 Scenario: 9 writes to 0x7 with NUM_FILTERS=4 -> 8 eq_wr_en pulses, eq_full=1, and a read of 0xE shows bit7=1.
REQ-033 Scenario: write 0x4, then assert reset on the next cycle -> no coef_wr_en, and all outputs are 0 during and after reset.
REQ-034 Scenario: drive audio_status_in=0x03 and read 0xB -> cpu_rdata=0x03; a write of 0xFF to 0xB leaves it unchanged.
